// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: NCH producer handshakes in, one register-file write port out.
// The arbiter uses the slave modport; the driving environment uses master.
interface wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int NCH  = 3
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]      in_valid;
    logic [NCH-1:0]      in_ready;
    logic [NCH*XLEN-1:0] in_data;
    logic [NCH*5-1:0]    in_adr;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_data;
    logic [4:0]          out_adr;
    logic [CHW-1:0]      out_ch;
    logic [31:0]         pend;

    modport slave (
        input  in_valid, in_data, in_adr, out_ready,
        output in_ready, out_valid, out_data, out_adr, out_ch, pend
    );

    modport master (
        output in_valid, in_data, in_adr, out_ready,
        input  in_ready, out_valid, out_data, out_adr, out_ch, pend
    );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: per-channel FIFOs drained onto one register-file write port.
// Latency: a packet accepted at edge t appears on out_* in cycle t+1; no comb input-to-output path.
// Backpressure: in_ready drops when a channel FIFO is full (no same-cycle pop credit); out holds while out_ready=0.
module wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int NCH   = 3,
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    wb_arbiter_if.slave bus
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [4:0]      adr;
    } entry_t;

    entry_t         mem    [NCH][DEPTH];
    logic [PW-1:0]  wr_ptr [NCH];
    logic [PW-1:0]  rd_ptr [NCH];
    logic [CW-1:0]  count  [NCH];
    logic [CHW-1:0] prio;
    logic [CHW-1:0] grant;
    logic           found;
    logic [NCH-1:0] nonempty;
    logic [NCH-1:0] ready;
    logic [NCH-1:0] push;
    logic [NCH-1:0] pop;
    logic           out_vld;
    logic           pop_fire;
    logic [31:0]    pend_mask;
    entry_t         head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // x0 writes complete the handshake but never enter the FIFO
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            nonempty[c] = (count[c] != '0);
            ready[c]    = (count[c] != CW'(DEPTH));
            push[c]     = bus.in_valid[c] && ready[c] && (bus.in_adr[c*5 +: 5] != 5'd0);
        end
    end

    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            idx = int'(prio) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (!found && nonempty[idx]) begin
                grant = CHW'(idx);
                found = 1'b1;
            end
        end
    end

    assign out_vld  = |nonempty;
    assign pop_fire = out_vld && bus.out_ready;

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            pop[c] = pop_fire && (grant == CHW'(c));
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy
    always_comb begin
        int off;
        off       = 0;
        pend_mask = '0;
        for (int c = 0; c < NCH; c++) begin
            for (int d = 0; d < DEPTH; d++) begin
                off = d - int'(rd_ptr[c]);
                if (off < 0) off = off + DEPTH;
                if (off < int'(count[c])) pend_mask[mem[c][d].adr] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
    end

    assign head          = mem[grant][rd_ptr[grant]];
    assign bus.in_ready  = ready;
    assign bus.out_valid = out_vld;
    assign bus.out_data  = head.data;
    assign bus.out_adr   = head.adr;
    assign bus.out_ch    = grant;
    assign bus.pend      = pend_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= '0;
            for (int c = 0; c < NCH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (push[c]) wr_ptr[c] <= ptr_inc(wr_ptr[c]);
                if (pop[c])  rd_ptr[c] <= ptr_inc(rd_ptr[c]);
                count[c] <= count[c] + CW'(push[c]) - CW'(pop[c]);
            end
            if (pop_fire) prio <= (int'(grant) == NCH - 1) ? '0 : grant + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (push[c]) mem[c][wr_ptr[c]] <= {bus.in_data[c*XLEN +: XLEN], bus.in_adr[c*5 +: 5]};
        end
    end
endmodule
